imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the ID stage; successor to the combinational sign-extender.
- Decodes all RV32I/RV64I immediate formats (I, shamt, S, B, U, J) from the instruction word into an XLEN-wide immediate, a format code and an illegal flag.
- Elastic valid/ready stage with a 1-entry skid buffer: full throughput, no combinational path from out_ready_i to in_ready_o, plus a synchronous flush for branch/jump squash.

Parameters:
- XLEN, 32, datapath and immediate width; legal values 32 or 64.
- SKID_EN, 1, 1 = skid buffer present; 0 = in_ready_o = !out_valid_o || out_ready_i (combinational).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous squash of all held entries.
- in_valid_i  input  1  instruction present.
- in_ready_o  output  1  stage can accept.
- inst_i  input  32  instruction word.
- pc_i  input  XLEN  PC tag, passed through.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts.
- imm_o  output  XLEN  extended immediate.
- fmt_o  output  3  0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 illegal.
- illegal_o  output  1  opcode not recognised.
- pc_o  output  XLEN  PC of the entry on imm_o.

Behaviour:
- Decode (opcode = inst[6:0]), computed combinationally at the input and registered:
  - LOAD 0000011, JALR 1100111, SYSTEM 1110011, OP-IMM 0010011 (funct3 not 001/101): I, imm = sext(inst[31:20]).
  - OP-IMM with funct3 001/101: SHAMT, imm = zext(inst[24:20]) for XLEN=32 or zext(inst[25:20]) for XLEN=64. funct7 bits are never part of the immediate.
  - STORE 0100011: S, sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011: B, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13 bits.
  - LUI 0110111 / AUIPC 0010111: U, sext({inst[31:12], 12'b0}).
  - JAL 1101111: J, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21 bits.
  - OP 0110011: fmt 0, imm 0.
  - Anything else: fmt 7, illegal_o = 1, imm 0.
  - All sign extension replicates the top immediate bit to XLEN.
- Handshake:
  - Input transfers on in_valid_i && in_ready_o. Output transfers on out_valid_o && out_ready_i.
  - Latency: 1 cycle from input transfer to out_valid_o when the stage is empty.
  - Throughput: 1 per cycle.
  - SKID_EN=1: in_ready_o = !skid_valid (registered).
    - If the input transfers while out_valid_o && !out_ready_i, the entry goes to the skid.
    - When the output drains, the skid entry moves to the output before any new input; order is strictly preserved.
  - Output registers hold their value while out_valid_o && !out_ready_i.
- States (SKID_EN=1): EMPTY (out 0, skid 0), ONE (out 1, skid 0), FULL (out 1, skid 1).
  - EMPTY -> ONE on input.
  - ONE -> EMPTY on drain with no input; ONE -> ONE on drain with input.
  - ONE -> FULL on input with no drain.
  - FULL -> ONE on drain; no input is accepted while FULL.
- flush_i (sampled at edge): out_valid_o and skid_valid clear next cycle; any input transferring in that cycle is discarded. flush_i has priority over every other event.
- Reset (asynchronous assert, any time including mid-transfer):
  - out_valid_o = 0, skid empty, imm_o = 0, fmt_o = 0, illegal_o = 0, pc_o = 0.
  - in_ready_o = 1 once rst_i is high (SKID_EN=1).

Test Plan:
- XLEN=32, inst 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, pc_o=0x100. With XLEN=64 -> imm_o=0xFFFFFFFFFFFFFFFF.
- Inst 0x41F0D093 (srai x1,x1,31) -> imm_o=0x0000001F, fmt_o=6 (funct7 masked, zero-extended).
- Inst 0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFFFFFC, fmt_o=3. Inst 0x123450B7 (lui) -> imm_o=0x12345000, fmt_o=4. Inst 0x0000007F -> illegal_o=1, fmt_o=7, imm_o=0.
- Backpressure, out_ready_i=0:
  - Present 3 back-to-back beats A, B, C -> A and B accepted, in_ready_o=0 while C is held.
  - Raise out_ready_i -> outputs A, B, C on consecutive cycles, none lost or duplicated.
- State FULL, assert flush_i for 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, the flush-cycle beat never appears.
- Drop rst_i asynchronously mid-stream in state FULL -> immediately out_valid_o=0, imm_o=0. After release, the first new beat appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate decoder behind a valid/ready stage with a 1-entry skid buffer
// Ports: clk_i/rst_i (async, active-low) clock and reset; flush_i squashes every held entry;
//        in_valid_i/in_ready_o/inst_i/pc_i form the input beat; out_valid_o/out_ready_i handshake
//        the result imm_o/fmt_o/illegal_o/pc_o.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic in_xfer, drain, load_in, load_from_skid, load_skid;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, dec_imm, skid_imm, skid_pc;
  logic [2:0] dec_fmt, skid_fmt;
  logic skid_ill;
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  // funct7 sits above the shift amount and must never leak into it
  assign imm_sh = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
  always_comb begin
    dec_imm = '0;
    dec_fmt = 3'd7;
    case (inst_i[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin dec_fmt = 3'd1; dec_imm = imm_i; end
      // funct3 001/101 (slli/srli/srai) share low bits 01
      7'b0010011: begin
        dec_fmt = (inst_i[13:12] == 2'b01) ? 3'd6 : 3'd1;
        dec_imm = (inst_i[13:12] == 2'b01) ? imm_sh : imm_i;
      end
      7'b0100011: begin dec_fmt = 3'd2; dec_imm = imm_s; end
      7'b1100011: begin dec_fmt = 3'd3; dec_imm = imm_b; end
      7'b0110111, 7'b0010111: begin dec_fmt = 3'd4; dec_imm = imm_u; end
      7'b1101111: begin dec_fmt = 3'd5; dec_imm = imm_j; end
      7'b0110011: dec_fmt = 3'd0;
      default: ;
    endcase
  end
  assign out_valid_o = state != EMPTY;
  // without the skid the ready path is combinational and FULL is never reached
  assign in_ready_o  = SKID_EN ? state != FULL : (state == EMPTY || out_ready_i);
  assign in_xfer     = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;
  assign load_in        = !flush_i && in_xfer && (state == EMPTY || drain);
  assign load_from_skid = !flush_i && state == FULL && drain;
  assign load_skid      = !flush_i && in_xfer && state == ONE && !drain;
  always_comb begin
    state_nxt = flush_i ? EMPTY :
                state == EMPTY ? (in_xfer ? ONE : EMPTY) :
                state == ONE   ? ((drain && !in_xfer) ? EMPTY : (!drain && in_xfer) ? FULL : ONE) :
                (drain ? ONE : FULL);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      imm_o     <= '0;
      fmt_o     <= '0;
      illegal_o <= 1'b0;
      pc_o      <= '0;
      skid_imm  <= '0;
      skid_fmt  <= '0;
      skid_ill  <= 1'b0;
      skid_pc   <= '0;
    end else begin
      if (load_in) begin
        imm_o     <= dec_imm;
        fmt_o     <= dec_fmt;
        illegal_o <= dec_fmt == 3'd7;
        pc_o      <= pc_i;
      end else if (load_from_skid) begin
        imm_o     <= skid_imm;
        fmt_o     <= skid_fmt;
        illegal_o <= skid_ill;
        pc_o      <= skid_pc;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_ill <= dec_fmt == 3'd7;
        skid_pc  <= pc_i;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe (XLEN 32 and 64) against a queue model
module tb_imm_gen_pipe;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] inst = 0, pc = 0;
  logic in_ready, out_valid, illegal, in_ready64, out_valid64, illegal64;
  logic [31:0] imm, pc_o;
  logic [63:0] imm64, pc_o64;
  logic [2:0] fmt, fmt64;
  imm_gen_pipe #(.XLEN(32), .SKID_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .fmt_o(fmt), .illegal_o(illegal), .pc_o(pc_o));
  imm_gen_pipe #(.XLEN(64), .SKID_EN(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .inst_i(inst), .pc_i({pc, pc}), .out_valid_o(out_valid64), .out_ready_i(out_ready),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(illegal64), .pc_o(pc_o64));
  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [2:0]  f;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen, output logic [2:0] f);
    longint s, hi;
    logic [63:0] r;
    s = $signed(ins);
    r = 0;
    f = 7;
    case (ins[6:0])
      7'h03, 7'h67, 7'h73: begin f = 1; r = s >>> 20; end
      7'h13:
        if (ins[14:12] == 1 || ins[14:12] == 5) begin
          f = 6;
          r = (ins >> 20) & ((xlen == 32) ? 31 : 63);
        end else begin
          f = 1;
          r = s >>> 20;
        end
      7'h23: begin f = 2; hi = s >>> 25; r = (hi << 5) | ins[11:7]; end
      7'h63: begin
        f = 3;
        hi = s >>> 31;
        r = (hi << 12) | (ins[7] << 11) | (ins[30:25] << 5) | (ins[11:8] << 1);
      end
      7'h37, 7'h17: begin f = 4; r = s & ~64'hFFF; end
      7'h6F: begin
        f = 5;
        hi = s >>> 31;
        r = (hi << 20) | (ins[19:12] << 12) | (ins[20] << 11) | (ins[30:21] << 1);
      end
      7'h33: f = 0;
      default: ;
    endcase
    return r;
  endfunction
  function automatic ent_t mk(input logic [31:0] ins, input logic [31:0] p);
    ent_t e;
    logic [63:0] w;
    logic [2:0] f;
    w = ref_imm(ins, 32, f);
    e.i32 = {32'h0, w[31:0]};
    e.i64 = ref_imm(ins, 64, f);
    e.f = f;
    e.pc = p;
    return e;
  endfunction
  task automatic cmp_model();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid64", out_valid64, q.size() > 0);
    chk("in_ready64", in_ready64, q.size() < 2);
    if (q.size() > 0) begin
      chk("imm", imm, q[0].i32);
      chk("fmt", fmt, q[0].f);
      chk("illegal", illegal, q[0].f == 7);
      chk("pc", pc_o, q[0].pc);
      chk("imm64", imm64, q[0].i64);
      chk("fmt64", fmt64, q[0].f);
      chk("pc64", pc_o64, {q[0].pc, q[0].pc});
    end
  endtask
  // holding up to two entries is the whole observable contract of the stage
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic r, input logic f);
    bit drn, acc;
    in_valid = v; inst = ins; pc = p; out_ready = r; flush = f;
    if (f) q.delete();
    else begin
      drn = q.size() > 0 && r;
      acc = v && q.size() < 2;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(mk(ins, p));
    end
    @(negedge clk);
    cmp_model();
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops[11] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 12);
    ins[6:0] = (k < 11) ? ops[k] : 7'($urandom);
    return ins;
  endfunction
  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", imm, 0);
    chk("rst_fmt", fmt, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc_o, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    cmp_model();
    step(1, 32'hFFF00093, 32'h100, 1, 0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_fmt", fmt, 1);
    chk("addi_pc", pc_o, 32'h100);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    step(1, 32'h41F0D093, 32'h104, 1, 0);
    chk("srai_imm", imm, 32'h1F);
    chk("srai_fmt", fmt, 6);
    step(1, 32'hFE000EE3, 32'h108, 1, 0);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_fmt", fmt, 3);
    step(1, 32'h123450B7, 32'h10C, 1, 0);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_fmt", fmt, 4);
    step(1, 32'h0000007F, 32'h110, 1, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_fmt", fmt, 7);
    chk("ill_imm", imm, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h00500093, 32'h200, 0, 0);
    step(1, 32'h00112623, 32'h204, 0, 0);
    step(1, 32'h008000EF, 32'h208, 0, 0);
    chk("bp_ready_c_held", in_ready, 0);
    chk("bp_head_a", pc_o, 32'h200);
    step(1, 32'h008000EF, 32'h208, 1, 0);
    chk("bp_b_imm", imm, 12);
    chk("bp_b_pc", pc_o, 32'h204);
    step(1, 32'h008000EF, 32'h208, 1, 0);
    chk("bp_c_imm", imm, 8);
    chk("bp_c_pc", pc_o, 32'h208);
    step(0, 0, 0, 1, 0);
    chk("bp_drained", out_valid, 0);
    step(1, 32'h00100093, 32'h300, 0, 0);
    step(1, 32'h00200093, 32'h304, 0, 0);
    step(1, 32'h00300093, 32'h308, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    step(0, 0, 0, 1, 0);
    chk("flush_no_beat", out_valid, 0);
    step(1, 32'h00100093, 32'h400, 0, 0);
    step(1, 32'h00200093, 32'h404, 0, 0);
    in_valid = 0;
    #2 rst = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_imm", imm, 0);
    chk("arst_pc", pc_o, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    cmp_model();
    step(1, 32'h123450B7, 32'h500, 1, 0);
    chk("arst_first_imm", imm, 32'h12345000);
    chk("arst_first_pc", pc_o, 32'h500);
    repeat (400) step($urandom_range(0, 3) != 0, rnd_inst(), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    repeat (3) step(0, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
